// File: rtl/bit_serializer_if.sv
`default_nettype none
// ============================================================================
// Module   : bit_serializer_if
// Purpose  : Word-vector input and bit-plane output handshake bundle.
// Revision : 1.0
// ============================================================================
interface bit_serializer_if #(
  parameter int w = 32,
  parameter int n = 8
);
  logic                 i_valid;
  logic                 i_ready;
  logic [n*w-1:0]       i_data;
  logic [$clog2(w):0]   i_prec;
  logic                 i_signed;
  logic                 o_valid;
  logic                 o_ready;
  logic [n-1:0]         o_bits;
  logic                 o_first;
  logic                 o_last;
  logic                 o_neg;

  modport master (
    output i_valid, i_data, i_prec, i_signed, o_ready,
    input  i_ready, o_valid, o_bits, o_first, o_last, o_neg
  );

  modport slave (
    input  i_valid, i_data, i_prec, i_signed, o_ready,
    output i_ready, o_valid, o_bits, o_first, o_last, o_neg
  );
endinterface
`default_nettype wire

// File: rtl/bit_serializer.sv
`default_nettype none
// ============================================================================
// Module   : bit_serializer
// Purpose  : Accepts n lane words and emits them MSB-first as n-bit planes.
// Revision : 1.0
// ============================================================================
module bit_serializer #(
  parameter int w = 32,
  parameter int n = 8
) (
  input  logic             clk,
  input  logic             clr,
  bit_serializer_if.slave  bus
);

  localparam int IW = $clog2(w);
  localparam int PW = $clog2(w) + 1;
  localparam logic [PW-1:0] C_W = PW'(w);

  logic [n*w-1:0] data_q,  data_d;
  logic [IW-1:0]  idx_q,   idx_d;
  logic           valid_q, valid_d;
  logic           first_q, first_d;
  logic           sign_q,  sign_d;

  logic           w_last;
  logic           w_accept;
  logic           w_advance;
  logic [PW-1:0]  w_prec;
  logic [IW-1:0]  w_idx;

  assign w_last    = valid_q & (idx_q == '0);
  assign bus.i_ready = ~valid_q | (bus.o_ready & w_last);
  assign w_accept  = bus.i_valid & bus.i_ready;
  assign w_advance = valid_q & bus.o_ready;

  // Precision beyond the word width is clamped, so the MSB plane is bit w-1.
  assign w_prec = (bus.i_prec > C_W) ? C_W : bus.i_prec;
  assign w_idx  = IW'(w_prec - PW'(1));

  always_comb begin
    data_d  = data_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    first_d = first_q;
    sign_d  = sign_q;
    if (w_accept) begin
      data_d  = bus.i_data;
      sign_d  = bus.i_signed;
      valid_d = (w_prec != '0);
      first_d = (w_prec != '0);
      idx_d   = (w_prec != '0) ? w_idx : '0;
    end else if (w_advance) begin
      first_d = 1'b0;
      if (idx_q == '0) begin
        valid_d = 1'b0;
      end else begin
        idx_d = idx_q - IW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      data_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      first_q <= 1'b0;
      sign_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      first_q <= first_d;
      sign_q  <= sign_d;
    end
  end

  for (genvar k = 0; k < n; k++) begin : g_lane
    logic [w-1:0] w_word;
    assign w_word        = data_q[k*w +: w];
    assign bus.o_bits[k] = w_word[idx_q];
  end

  assign bus.o_valid = valid_q;
  assign bus.o_first = first_q;
  assign bus.o_last  = w_last;
  // Only the MSB plane of a two's-complement word carries negative weight.
  assign bus.o_neg   = sign_q & first_q;

endmodule
`default_nettype wire

// File: tb/tb_bit_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_bit_serializer
// Purpose  : Directed vector bench for bit_serializer (w=32, n=8).
// Revision : 1.0
// ============================================================================
module tb_bit_serializer;

  logic clk;
  logic clr;
  int   checks;
  int   errors;
  int   step;
  int   acc [2];

  bit_serializer_if #(.w(32), .n(8)) bus ();

  bit_serializer #(.w(32), .n(8)) u_dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         iv;
    logic [255:0] d;
    logic [5:0]   p;
    logic         s;
    logic         ordy;
    logic         e_ir;
    logic         e_ov;
    logic [7:0]   e_b;
    logic         e_f;
    logic         e_l;
    logic         e_n;
  } vec_t;

  localparam int NV = 14;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic iv, input logic [255:0] d, input logic [5:0] p,
                              input logic s, input logic ordy, input logic e_ir,
                              input logic e_ov, input logic [7:0] e_b, input logic e_f,
                              input logic e_l, input logic e_n);
    vec_t v;
    v.iv = iv; v.d = d; v.p = p; v.s = s; v.ordy = ordy;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_b = e_b; v.e_f = e_f; v.e_l = e_l; v.e_n = e_n;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @step %0d: got %0h, expected %0h", nm, step, act, exp);
    end
  endtask

  // One cycle: drive at the falling edge, check just after, then the rising edge commits.
  task automatic cyc(input string nm, input logic iv, input logic [255:0] d, input logic [5:0] p,
                     input logic s, input logic ordy, input logic e_ir, input logic e_ov,
                     input logic [7:0] e_b, input logic e_f, input logic e_l, input logic e_n);
    logic b;
    @(negedge clk);
    bus.i_valid  = iv;
    bus.i_data   = d;
    bus.i_prec   = p;
    bus.i_signed = s;
    bus.o_ready  = ordy;
    #1;
    chk({nm, ".i_ready"}, 32'(bus.i_ready), 32'(e_ir));
    chk({nm, ".o_valid"}, 32'(bus.o_valid), 32'(e_ov));
    if (e_ov) chk({nm, ".o_bits"}, 32'(bus.o_bits), 32'(e_b));
    chk({nm, ".o_first"}, 32'(bus.o_first), 32'(e_f));
    chk({nm, ".o_last"},  32'(bus.o_last),  32'(e_l));
    chk({nm, ".o_neg"},   32'(bus.o_neg),   32'(e_n));
    if (bus.o_valid && ordy) begin
      for (int k = 0; k < 2; k++) begin
        b = bus.o_bits[k];
        if (bus.o_first) acc[k] = bus.o_neg ? -int'(b) : int'(b);
        else             acc[k] = acc[k] * 2 + int'(b);
      end
    end
    step++;
  endtask

  localparam logic [255:0] D_A  = {192'h0, 32'h0000005A, 32'h000000A5};
  localparam logic [255:0] D_S  = {192'h0, 32'h00000005, 32'hFFFFFFFD};
  localparam logic [255:0] D_40 = {32'hFFFFFFFF, 192'h0, 32'h80000001};

  initial begin
    checks = 0; errors = 0; step = 0;
    acc[0] = 0; acc[1] = 0;
    clr = 1'b1;
    bus.i_valid = 1'b0; bus.i_data = '0; bus.i_prec = '0; bus.i_signed = 1'b0; bus.o_ready = 1'b0;

    // Unsigned A5/5A over 8 planes, then a no-bubble handoff to a signed -3/+5 word.
    tbl[0]  = mk(1'b1, D_A, 6'd8, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    tbl[1]  = mk(1'b0, '0,  6'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0);
    tbl[2]  = mk(1'b0, '0,  6'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
    tbl[3]  = mk(1'b0, '0,  6'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
    tbl[4]  = mk(1'b0, '0,  6'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
    tbl[5]  = mk(1'b0, '0,  6'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
    tbl[6]  = mk(1'b0, '0,  6'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
    tbl[7]  = mk(1'b0, '0,  6'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
    tbl[8]  = mk(1'b1, D_S, 6'd4, 1'b1, 1'b1, 1'b1, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0);
    tbl[9]  = mk(1'b0, '0,  6'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 1'b1);
    tbl[10] = mk(1'b0, '0,  6'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
    tbl[11] = mk(1'b0, '0,  6'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
    tbl[12] = mk(1'b0, '0,  6'd0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h03, 1'b0, 1'b1, 1'b0);
    tbl[13] = mk(1'b0, '0,  6'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    clr = 1'b0;
    #1;
    chk("rst.o_valid", 32'(bus.o_valid), 32'd0);
    chk("rst.o_bits",  32'(bus.o_bits),  32'd0);
    chk("rst.o_first", 32'(bus.o_first), 32'd0);
    chk("rst.o_last",  32'(bus.o_last),  32'd0);
    chk("rst.o_neg",   32'(bus.o_neg),   32'd0);
    chk("rst.i_ready", 32'(bus.i_ready), 32'd1);

    for (int i = 0; i < NV; i++) begin
      cyc($sformatf("tbl%0d", i), tbl[i].iv, tbl[i].d, tbl[i].p, tbl[i].s, tbl[i].ordy,
          tbl[i].e_ir, tbl[i].e_ov, tbl[i].e_b, tbl[i].e_f, tbl[i].e_l, tbl[i].e_n);
    end
    chk("acc.lane0", 32'(acc[0]), 32'hFFFFFFFD);
    chk("acc.lane1", 32'(acc[1]), 32'd5);

    // Back-to-back prec=3 words with i_valid held: 110 then 011.
    cyc("b2b", 1'b1, 256'h6, 6'd3, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    cyc("b2b", 1'b1, 256'h3, 6'd3, 1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0);
    cyc("b2b", 1'b1, 256'h3, 6'd3, 1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
    cyc("b2b", 1'b1, 256'h3, 6'd3, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
    cyc("b2b", 1'b0, '0,     6'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    cyc("b2b", 1'b0, '0,     6'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
    cyc("b2b", 1'b0, '0,     6'd0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0);
    cyc("b2b", 1'b0, '0,     6'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Stall on plane 2 for 3 cycles while a competing word is offered and must be ignored.
    cyc("stall", 1'b1, {192'h0, 32'h5, 32'hA}, 6'd4, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    cyc("stall", 1'b0, '0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      cyc("stall", 1'b1, '1, 6'd7, 1'b1, 1'b0, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
    cyc("stall", 1'b0, '0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
    cyc("stall", 1'b0, '0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
    cyc("stall", 1'b0, '0, 6'd0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h02, 1'b0, 1'b1, 1'b0);
    cyc("stall", 1'b0, '0, 6'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // prec=0 is dropped; prec=40 clamps to 32 planes.
    cyc("p0",    1'b1, '1, 6'd0, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    cyc("p0",    1'b0, '0, 6'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    cyc("p40",   1'b1, D_40, 6'd40, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 31; i >= 0; i--)
      cyc("p40", 1'b0, '0, 6'd0, 1'b0, 1'b1, (i == 0), 1'b1,
          {1'b1, 6'b0, (i == 31 || i == 0)}, (i == 31), (i == 0), 1'b0);
    cyc("p40",   1'b0, '0, 6'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // clr on plane 4 wins over the handshake; the next word restarts from its MSB.
    cyc("clr", 1'b1, 256'hFF, 6'd8, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      cyc("clr", 1'b0, '0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h01, (i == 0), 1'b0, 1'b0);
    @(negedge clk);
    clr = 1'b1;
    bus.i_valid = 1'b0;
    bus.o_ready = 1'b1;
    #1;
    chk("clr.plane4", 32'(bus.o_bits), 32'h01);
    @(negedge clk);
    clr = 1'b0;
    #1;
    chk("clr.o_valid", 32'(bus.o_valid), 32'd0);
    chk("clr.o_bits",  32'(bus.o_bits),  32'd0);
    chk("clr.o_first", 32'(bus.o_first), 32'd0);
    chk("clr.o_last",  32'(bus.o_last),  32'd0);
    chk("clr.o_neg",   32'(bus.o_neg),   32'd0);
    chk("clr.i_ready", 32'(bus.i_ready), 32'd1);
    cyc("clr", 1'b1, 256'h2, 6'd2, 1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    cyc("clr", 1'b0, '0, 6'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 1'b1);
    cyc("clr", 1'b0, '0, 6'd0, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0);
    cyc("clr", 1'b0, '0, 6'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
